polar_frame_writer: RTL and testbench
=====================================

# polar_frame_writer

- Parametrised successor to the single-shot polar-frame AXI master.
- Captures one complete polar frame (NO_DELTA_INTERVALS × NO_ARM_LED × RGB_SIZE bits) from the cartesian-to-polar mapper.
- Writes the frame word-by-word into LED-driver BRAM over an AXI4-Lite write master, using an N-way rotating set of frame buffers instead of a fixed ping-pong pair.
- Reports the index of the last fully written buffer to the LED driver, and flags write errors.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width in bits; must divide FRAME_BITS.
- ADDR_WIDTH, 32, AXI address width.
- NO_ARM_LED, 32, LEDs per arm.
- NO_DELTA_INTERVALS, 18, angular steps per revolution.
- RGB_SIZE, 8, bits per LED entry.
- NUM_BUFFERS, 2, frame buffers in BRAM; ≥1, ≤16.
- BRAM_BASE_ADDR, 'h0, byte address of buffer 0.
- BRAM_ADDR_OFF, 16000, byte stride between buffers.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with FRAME_WR_TIMEOUT_EN.
- Derived values (not overridable): FRAME_BITS = NO_DELTA_INTERVALS*NO_ARM_LED*RGB_SIZE; WORDS = FRAME_BITS/DATA_WIDTH.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- frame_data  in  FRAME_BITS  polar frame from mapper.
- frame_valid  in  1  frame_data is stable and complete.
- frame_ready  out  1  high only in IDLE; the frame is accepted on the edge where frame_valid&frame_ready.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1.
- m_axi_awready  in  1.
- m_axi_wdata  out  DATA_WIDTH.
- m_axi_wstrb  out  DATA_WIDTH/8  constant all ones.
- m_axi_wvalid  out  1.
- m_axi_wready  in  1.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a frame has completed.
- disp_buf  out  clog2(NUM_BUFFERS) (min 1)  last completed buffer index.
- wr_error  out  1  sticky; set by a non-OKAY bresp or a timeout.

## Operation
- States: IDLE, ISSUE, RESP, DONE.
- IDLE: frame_ready=1. On accept:
  - latch frame_data into the shift register;
  - word_idx=0;
  - clear wr_error;
  - load awaddr = BRAM_BASE_ADDR + wr_buf*BRAM_ADDR_OFF;
  - load wdata = frame[DATA_WIDTH-1:0];
  - go to ISSUE.
- ISSUE: awvalid and wvalid start high together.
  - Each drops independently on the edge of its own handshake.
  - Once both handshakes are complete (same or different cycles), go to RESP.
  - awaddr and wdata hold stable while their valid is high.
- RESP: bready=1.
  - On bvalid: if bresp≠2'b00, set wr_error.
  - If word_idx==WORDS-1, go to DONE.
  - Otherwise, on the same edge: word_idx+1, awaddr += DATA_WIDTH/8 (byte addressing), shift register right by DATA_WIDTH, load the next wdata, go to ISSUE.
- DONE (one cycle):
  - done=1;
  - disp_buf ← wr_buf;
  - wr_buf ← (wr_buf+1) mod NUM_BUFFERS;
  - go to IDLE.
- Word order: LSB first. Word k = frame[k*DATA_WIDTH +: DATA_WIDTH].
- Errors do not abort the frame. The frame still completes and the buffer still rotates.
- NUM_BUFFERS=1: wr_buf and disp_buf stay 0.
- Address arithmetic is modulo 2^ADDR_WIDTH.
- frame_valid is ignored outside IDLE. Changes to frame_data after accept have no effect.

## Timing
- Reset values: frame_ready=0 during reset, then 1 on the first cycle out of reset (IDLE).
  - awvalid, wvalid, bready, busy, done, wr_error = 0.
  - awaddr = BRAM_BASE_ADDR; wdata = 0; disp_buf = 0; wr_buf = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- Accept edge → awvalid/wvalid high in the next cycle.
- Minimum 2 cycles per word: ISSUE with ready high, then RESP with bvalid high.
- Minimum accept-to-done latency: 2*WORDS+1 cycles.
- frame_ready returns high in the cycle after done.
- Back-to-back frames: accept is possible in the first IDLE cycle.
- Reset asserted mid-frame: immediate return to reset values.
  - The partial buffer is abandoned and disp_buf reverts to 0.
  - No handshake completes after reset assertion.

## Configuration
- FRAME_WR_TIMEOUT_EN defined:
  - A counter runs in ISSUE and RESP. It clears on every handshake (aw, w or b).
  - On reaching TIMEOUT_CYCLES: drop all valids and bready, set wr_error, go to IDLE.
  - In that case there is no done pulse, no disp_buf update and no wr_buf rotation.
- FRAME_WR_TIMEOUT_EN undefined: no counter. The block waits indefinitely, and the TIMEOUT_CYCLES parameter is unused.

## Test plan
Bench parameters: NO_ARM_LED=4, NO_DELTA_INTERVALS=2, RGB_SIZE=8, DATA_WIDTH=32, NUM_BUFFERS=3, BRAM_BASE_ADDR='h100, BRAM_ADDR_OFF='h40 (WORDS=2).

- Always-ready slave, frame_data=64'h1122334455667788 → two writes: ('h100, 'h55667788) then ('h104, 'h11223344).
  - done pulses exactly 5 cycles after the accept edge; disp_buf=0.
- Three further frames → base addresses 'h140, 'h180, 'h100; disp_buf sequence 1, 2, 0.
- awready delayed 3 cycles while wready is immediate → wvalid drops after 1 cycle, awvalid after 4, and awaddr/wdata stay stable throughout.
  - Exactly one write per word.
- bresp=2'b10 on word 0 → wr_error=1 through done; the frame completes and disp_buf updates.
  - The next accept clears wr_error.
- Reset asserted during RESP of word 1 → all outputs return to reset values asynchronously.
  - The next frame writes to 'h100.
- With FRAME_WR_TIMEOUT_EN and TIMEOUT_CYCLES=8, bvalid never asserted → 8 cycles into RESP: bready=0, wr_error=1, IDLE.
  - No done pulse; disp_buf unchanged.

Source files
------------

// File: rtl/polar_frame_writer_if.sv
// ============================================================================
// Module      : polar_frame_writer_if
// Description : AXI4-Lite write-channel bundle between the polar frame writer
//               (master) and the LED-driver BRAM controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface polar_frame_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready
    );
endinterface

`default_nettype wire

// File: rtl/polar_frame_writer.sv
// ============================================================================
// Module      : polar_frame_writer
// Description : Captures a polar frame and writes it word-by-word over AXI4-Lite
//               into an N-way rotating set of BRAM frame buffers.
//               Optional watchdog: define FRAME_WR_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module polar_frame_writer #(
    parameter int                    DATA_WIDTH         = 32,
    parameter int                    ADDR_WIDTH         = 32,
    parameter int                    NO_ARM_LED         = 32,
    parameter int                    NO_DELTA_INTERVALS = 18,
    parameter int                    RGB_SIZE           = 8,
    parameter int                    NUM_BUFFERS        = 2,
    parameter logic [ADDR_WIDTH-1:0] BRAM_BASE_ADDR     = '0,
    parameter int                    BRAM_ADDR_OFF      = 16000,
    parameter int                    TIMEOUT_CYCLES     = 1024,
    localparam int c_FRAME_BITS = NO_DELTA_INTERVALS * NO_ARM_LED * RGB_SIZE,
    localparam int c_BUF_W      = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  wire logic                    clock,
    input  wire logic                    reset,
    input  wire logic [c_FRAME_BITS-1:0] frame_data,
    input  wire logic                    frame_valid,
    output logic                         frame_ready,
    polar_frame_writer_if.master         axi,
    output logic                         busy,
    output logic                         done,
    output logic [c_BUF_W-1:0]           disp_buf,
    output logic                         wr_error
);

    localparam int c_WORDS = c_FRAME_BITS / DATA_WIDTH;
    localparam int c_IDX_W = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;

    localparam logic [c_IDX_W-1:0]    c_LAST_WORD  = c_IDX_W'(c_WORDS - 1);
    localparam logic [c_BUF_W-1:0]    c_LAST_BUF   = c_BUF_W'(NUM_BUFFERS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] c_BUF_STRIDE = ADDR_WIDTH'(BRAM_ADDR_OFF);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;

    logic                    r_frame_ready, r_busy, r_done;
    logic                    r_awvalid, r_wvalid, r_bready;
    logic                    w_frame_ready_d, w_busy_d, w_done_d;
    logic                    w_awvalid_d, w_wvalid_d, w_bready_d;

    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_FRAME_BITS-1:0] w_shift_nxt;
    logic [c_IDX_W-1:0]      r_word_idx;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [ADDR_WIDTH-1:0]   w_buf_base;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_BUF_W-1:0]      r_wr_buf, r_disp_buf, w_wr_buf_nxt;
    logic                    r_wr_error;

    logic w_accept, w_aw_hs, w_w_hs, w_b_hs, w_any_hs;
    logic w_aw_clear, w_w_clear, w_last, w_active, w_timeout;

    assign w_accept    = r_frame_ready & frame_valid;
    assign w_aw_hs     = r_awvalid & axi.m_axi_awready;
    assign w_w_hs      = r_wvalid & axi.m_axi_wready;
    assign w_b_hs      = r_bready & axi.m_axi_bvalid;
    assign w_any_hs    = w_aw_hs | w_w_hs | w_b_hs;
    // A channel is finished when its valid is already low or handshakes now
    assign w_aw_clear  = ~r_awvalid | axi.m_axi_awready;
    assign w_w_clear   = ~r_wvalid | axi.m_axi_wready;
    assign w_last      = (r_word_idx == c_LAST_WORD);
    assign w_active    = (r_state == c_ST_ISSUE) | (r_state == c_ST_RESP);

    assign w_shift_nxt  = r_shift >> DATA_WIDTH;
    assign w_buf_base   = BRAM_BASE_ADDR + ADDR_WIDTH'(r_wr_buf) * c_BUF_STRIDE;
    assign w_wr_buf_nxt = (r_wr_buf == c_LAST_BUF) ? '0 : r_wr_buf + 1'b1;

`ifdef FRAME_WR_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    // Counts consecutive cycles without any channel making progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_to_cnt <= '0;
        else if (w_active && !w_any_hs)
            r_to_cnt <= r_to_cnt + 1'b1;
        else
            r_to_cnt <= '0;
    end

    assign w_timeout = w_active & ~w_any_hs & (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^{TIMEOUT_CYCLES, w_active, w_any_hs};
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: begin
                if (w_timeout)
                    w_state_nxt = c_ST_IDLE;
                else if (w_aw_clear && w_w_clear)
                    w_state_nxt = c_ST_RESP;
            end
            c_ST_RESP: begin
                if (w_timeout)
                    w_state_nxt = c_ST_IDLE;
                else if (axi.m_axi_bvalid)
                    w_state_nxt = w_last ? c_ST_DONE : c_ST_ISSUE;
            end
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered control outputs, decoded from the next state
    always_comb begin
        w_frame_ready_d = (w_state_nxt == c_ST_IDLE);
        w_busy_d        = (w_state_nxt != c_ST_IDLE);
        w_done_d        = (w_state_nxt == c_ST_DONE);
        w_bready_d      = (w_state_nxt == c_ST_RESP);
        w_awvalid_d     = 1'b0;
        w_wvalid_d      = 1'b0;
        if (w_state_nxt == c_ST_ISSUE) begin
            if (r_state == c_ST_ISSUE) begin
                w_awvalid_d = r_awvalid & ~axi.m_axi_awready;
                w_wvalid_d  = r_wvalid & ~axi.m_axi_wready;
            end else begin
                w_awvalid_d = 1'b1;
                w_wvalid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_frame_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
        end else begin
            r_frame_ready <= w_frame_ready_d;
            r_busy        <= w_busy_d;
            r_done        <= w_done_d;
            r_awvalid     <= w_awvalid_d;
            r_wvalid      <= w_wvalid_d;
            r_bready      <= w_bready_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_word_idx <= '0;
            r_awaddr   <= BRAM_BASE_ADDR;
            r_wdata    <= '0;
            r_wr_buf   <= '0;
            r_disp_buf <= '0;
            r_wr_error <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= frame_data;
                        r_word_idx <= '0;
                        r_wr_error <= 1'b0;
                        r_awaddr   <= w_buf_base;
                        r_wdata    <= frame_data[DATA_WIDTH-1:0];
                    end
                end
                c_ST_ISSUE: begin
                    if (w_timeout)
                        r_wr_error <= 1'b1;
                end
                c_ST_RESP: begin
                    if (w_timeout) begin
                        r_wr_error <= 1'b1;
                    end else if (axi.m_axi_bvalid) begin
                        if (axi.m_axi_bresp != 2'b00)
                            r_wr_error <= 1'b1;
                        if (!w_last) begin
                            r_word_idx <= r_word_idx + 1'b1;
                            r_awaddr   <= r_awaddr + c_WORD_BYTES;
                            r_shift    <= w_shift_nxt;
                            r_wdata    <= w_shift_nxt[DATA_WIDTH-1:0];
                        end
                    end
                end
                c_ST_DONE: begin
                    r_disp_buf <= r_wr_buf;
                    r_wr_buf   <= w_wr_buf_nxt;
                end
                default: ;
            endcase
        end
    end

    assign frame_ready       = r_frame_ready;
    assign busy              = r_busy;
    assign done              = r_done;
    assign disp_buf          = r_disp_buf;
    assign wr_error          = r_wr_error;
    assign axi.m_axi_awaddr  = r_awaddr;
    assign axi.m_axi_awvalid = r_awvalid;
    assign axi.m_axi_wdata   = r_wdata;
    assign axi.m_axi_wstrb   = '1;
    assign axi.m_axi_wvalid  = r_wvalid;
    assign axi.m_axi_bready  = r_bready;

endmodule

`default_nettype wire

// File: tb/tb_polar_frame_writer.sv
// ============================================================================
// Module      : tb_polar_frame_writer
// Description : Directed self-checking bench for polar_frame_writer (WORDS=2,
//               three buffers). Timeout steps run when FRAME_WR_TIMEOUT_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_polar_frame_writer;

    localparam int c_DW = 32;
    localparam int c_AW = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        busy;
    logic        done;
    logic [1:0]  disp_buf;
    logic        wr_error;

    int total = 0;
    int bad   = 0;
    int b_cnt = 0;
    int done_cnt = 0;
    int cyc;
    int done_before;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];

    polar_frame_writer_if #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) axi ();

    polar_frame_writer #(
        .DATA_WIDTH         (c_DW),
        .ADDR_WIDTH         (c_AW),
        .NO_ARM_LED         (4),
        .NO_DELTA_INTERVALS (2),
        .RGB_SIZE           (8),
        .NUM_BUFFERS        (3),
        .BRAM_BASE_ADDR     (32'h100),
        .BRAM_ADDR_OFF      ('h40),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .axi         (axi),
        .busy        (busy),
        .done        (done),
        .disp_buf    (disp_buf),
        .wr_error    (wr_error)
    );

    always #5 clock = ~clock;

    // Slave-side monitor: records every completed handshake and done pulse
    always @(posedge clock) begin
        if (!reset) begin
            if (axi.m_axi_awvalid && axi.m_axi_awready) aw_q.push_back(axi.m_axi_awaddr);
            if (axi.m_axi_wvalid && axi.m_axi_wready)   w_q.push_back(axi.m_axi_wdata);
            if (axi.m_axi_bvalid && axi.m_axi_bready)   b_cnt++;
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a frame, waits for the accept edge, then scrambles frame_data
    task automatic send_frame(input logic [63:0] d);
        frame_data  = d;
        frame_valid = 1'b1;
        for (int i = 0; i < 20 && frame_ready !== 1'b1; i++) tick();
        check("ready_before_accept", frame_ready, 1);
        tick();
        frame_valid = 1'b0;
        frame_data  = ~d;
    endtask

    // Returns the cycle (1 = first cycle after accept) in which done is seen, 0 if never
    task automatic wait_done(output int c);
        c = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done === 1'b1) begin
                c = i;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        frame_data         = '0;
        frame_valid        = 1'b0;
        axi.m_axi_awready  = 1'b1;
        axi.m_axi_wready   = 1'b1;
        axi.m_axi_bvalid   = 1'b1;
        axi.m_axi_bresp    = 2'b00;

        // Reset values
        tick();
        tick();
        check("rst_frame_ready", frame_ready, 0);
        check("rst_awvalid", axi.m_axi_awvalid, 0);
        check("rst_wvalid", axi.m_axi_wvalid, 0);
        check("rst_bready", axi.m_axi_bready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_error", wr_error, 0);
        check("rst_awaddr", axi.m_axi_awaddr, 'h100);
        check("rst_wdata", axi.m_axi_wdata, 0);
        check("rst_disp_buf", disp_buf, 0);
        check("rst_wstrb", axi.m_axi_wstrb, 'hF);
        reset = 1'b0;
        tick();
        check("idle_frame_ready", frame_ready, 1);

        // Frame 1: always-ready slave, minimum latency
        send_frame(64'h1122334455667788);
        check("f1_busy", busy, 1);
        check("f1_frame_ready_low", frame_ready, 0);
        wait_done(cyc);
        check("f1_latency", cyc, 5);
        check("f1_disp_at_done", disp_buf, 0);
        tick();
        check("f1_ready_after_done", frame_ready, 1);
        check("f1_done_cleared", done, 0);
        check("f1_done_count", done_cnt, 1);
        check("f1_disp_buf", disp_buf, 0);
        check("f1_aw_count", aw_q.size(), 2);
        check("f1_w_count", w_q.size(), 2);
        check("f1_addr0", aw_q[0], 'h100);
        check("f1_addr1", aw_q[1], 'h104);
        check("f1_data0", w_q[0], 'h55667788);
        check("f1_data1", w_q[1], 'h11223344);
        aw_q.delete();
        w_q.delete();

        // Frames 2-4: buffer rotation, accept in the first IDLE cycle
        send_frame(64'hCAFEF00D_00000002);
        wait_done(cyc);
        check("f2_latency", cyc, 5);
        tick();
        check("f2_disp_buf", disp_buf, 1);
        check("f2_addr0", aw_q[0], 'h140);
        check("f2_addr1", aw_q[1], 'h144);
        check("f2_data1", w_q[1], 'hCAFEF00D);
        aw_q.delete();
        w_q.delete();

        send_frame(64'h33333333_00000003);
        wait_done(cyc);
        check("f3_done_seen", cyc != 0, 1);
        tick();
        check("f3_disp_buf", disp_buf, 2);
        check("f3_addr0", aw_q[0], 'h180);
        aw_q.delete();
        w_q.delete();

        send_frame(64'h44444444_00000004);
        wait_done(cyc);
        check("f4_done_seen", cyc != 0, 1);
        tick();
        check("f4_disp_buf", disp_buf, 0);
        check("f4_addr0", aw_q[0], 'h100);
        check("f4_data0", w_q[0], 'h00000004);
        aw_q.delete();
        w_q.delete();

        // Frame 5: awready held low for the first three ISSUE cycles of word 0
        axi.m_axi_awready = 1'b0;
        send_frame(64'hA5A50000_DEADBEEF);
        check("f5_c1_awvalid", axi.m_axi_awvalid, 1);
        check("f5_c1_wvalid", axi.m_axi_wvalid, 1);
        check("f5_c1_awaddr", axi.m_axi_awaddr, 'h140);
        check("f5_c1_wdata", axi.m_axi_wdata, 'hDEADBEEF);
        tick();
        check("f5_c2_wvalid", axi.m_axi_wvalid, 0);
        check("f5_c2_awvalid", axi.m_axi_awvalid, 1);
        check("f5_c2_awaddr", axi.m_axi_awaddr, 'h140);
        tick();
        tick();
        check("f5_c4_awvalid", axi.m_axi_awvalid, 1);
        check("f5_c4_awaddr", axi.m_axi_awaddr, 'h140);
        check("f5_c4_wdata", axi.m_axi_wdata, 'hDEADBEEF);
        check("f5_c4_bready", axi.m_axi_bready, 0);
        axi.m_axi_awready = 1'b1;
        tick();
        check("f5_c5_awvalid", axi.m_axi_awvalid, 0);
        check("f5_c5_bready", axi.m_axi_bready, 1);
        wait_done(cyc);
        check("f5_done_seen", cyc != 0, 1);
        tick();
        check("f5_aw_count", aw_q.size(), 2);
        check("f5_w_count", w_q.size(), 2);
        check("f5_addr1", aw_q[1], 'h144);
        check("f5_data1", w_q[1], 'hA5A50000);
        check("f5_disp_buf", disp_buf, 1);
        aw_q.delete();
        w_q.delete();

        // Frame 6: SLVERR on word 0
        b_cnt = 0;
        axi.m_axi_bresp = 2'b10;
        send_frame(64'h0F0F0F0F_F0F0F0F0);
        for (int i = 0; i < 20 && b_cnt == 0; i++) tick();
        axi.m_axi_bresp = 2'b00;
        check("f6_b_seen", b_cnt, 1);
        check("f6_wr_error_set", wr_error, 1);
        wait_done(cyc);
        check("f6_done_seen", cyc != 0, 1);
        check("f6_wr_error_at_done", wr_error, 1);
        tick();
        check("f6_disp_buf", disp_buf, 2);
        check("f6_addr0", aw_q[0], 'h180);
        check("f6_wr_error_sticky", wr_error, 1);
        aw_q.delete();
        w_q.delete();

        // Frame 7: accept clears wr_error, then reset lands in RESP of word 1
        send_frame(64'h77777777_66666666);
        check("f7_wr_error_cleared", wr_error, 0);
        tick();
        tick();
        axi.m_axi_bvalid = 1'b0;
        tick();
        check("f7_resp1_bready", axi.m_axi_bready, 1);
        check("f7_resp1_awaddr", axi.m_axi_awaddr, 'h104);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_frame_ready", frame_ready, 0);
        check("mid_rst_awvalid", axi.m_axi_awvalid, 0);
        check("mid_rst_wvalid", axi.m_axi_wvalid, 0);
        check("mid_rst_bready", axi.m_axi_bready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_awaddr", axi.m_axi_awaddr, 'h100);
        check("mid_rst_wdata", axi.m_axi_wdata, 0);
        check("mid_rst_disp_buf", disp_buf, 0);
        tick();
        axi.m_axi_bvalid = 1'b1;
        aw_q.delete();
        w_q.delete();
        reset = 1'b0;
        tick();

        // Frame 8: first frame after reset lands in buffer 0
        send_frame(64'h01234567_89ABCDEF);
        wait_done(cyc);
        check("f8_latency", cyc, 5);
        tick();
        check("f8_addr0", aw_q[0], 'h100);
        check("f8_data0", w_q[0], 'h89ABCDEF);
        check("f8_disp_buf", disp_buf, 0);
        aw_q.delete();
        w_q.delete();

`ifdef FRAME_WR_TIMEOUT_EN
        // Frame 9: bvalid never arrives, watchdog abandons the frame
        axi.m_axi_bvalid = 1'b0;
        done_before = done_cnt;
        send_frame(64'h99999999_88888888);
        tick();
        check("to_resp_bready", axi.m_axi_bready, 1);
        repeat (7) tick();
        check("to_before_expiry", axi.m_axi_bready, 1);
        tick();
        check("to_bready_dropped", axi.m_axi_bready, 0);
        check("to_wr_error", wr_error, 1);
        check("to_frame_ready", frame_ready, 1);
        check("to_busy", busy, 0);
        tick();
        check("to_no_done", done_cnt, done_before);
        check("to_disp_buf", disp_buf, 0);
        axi.m_axi_bvalid = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
